// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the pattern burst writer slice.
//   PAT_*   : values of the 2-bit mode input (constant, increment,
//             checkerboard, walking one)
//   state_t : burst state machine encoding (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package pattern_pkg;

    localparam logic [1:0] PAT_CONST   = 2'd0;
    localparam logic [1:0] PAT_INC     = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_WALK1   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_burst_writer_if.sv
// -----------------------------------------------------------------------------
// pattern_burst_writer_if
// Write-FIFO port between the pattern writer (master) and the SDRAM write
// FIFO (slave).
//   fifo_wr_clk  : write clock, master -> slave
//   fifo_wr_en   : write strobe, master -> slave
//   fifo_wr_data : write word, master -> slave
//   fifo_full    : FIFO full, slave -> master
// Handshake: fifo_wr_en is already qualified by ~fifo_full, so it acts as
// valid & ready combined. A word transfers at every rising fifo_wr_clk edge
// where fifo_wr_en is 1; fifo_wr_data holds its value until that edge.
// -----------------------------------------------------------------------------
interface pattern_burst_writer_if #(
    parameter int DW = 16
);

    logic          fifo_wr_clk;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_full;

    modport master (
        output fifo_wr_clk,
        output fifo_wr_en,
        output fifo_wr_data,
        input  fifo_full
    );

    modport slave (
        input  fifo_wr_clk,
        input  fifo_wr_en,
        input  fifo_wr_data,
        output fifo_full
    );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises the raw active-low push button and accepts a level change
// only after DEBOUNCE_CYC consecutive samples that differ from the
// accepted level.
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_key      : raw key, asynchronous to clk
//   o_key_db   : debounced key level (1 = released)
//   o_press    : one-cycle pulse at the edge where o_key_db goes 1 -> 0
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_key_db,
    output logic o_press
);

    localparam int            CW    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_key_db;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_update;

    assign w_differ = (r_sync2 != r_key_db);
    assign w_update = w_differ && (r_cnt == LIMIT);

    // Reset to 1 everywhere so a released key produces no spurious press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_key_db <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_update) begin
                r_key_db <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_key_db = r_key_db;
    assign o_press  = w_update & r_key_db & ~r_sync2;

endmodule

// File: rtl/pattern_burst_writer.sv
// -----------------------------------------------------------------------------
// pattern_burst_writer
// On a debounced key press, writes one burst of BURST_LEN pattern words into
// the SDRAM write FIFO, stalling while the FIFO is full.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   i_key           : raw push button, active-low
//   i_mode          : pattern select, latched at burst start
//   o_busy          : burst in progress (state RUN)
//   o_done          : one-cycle pulse after the last word is accepted
//   o_words_written : words accepted in the current or most recent burst
//   o_key_db        : debounced key level
//   o_state         : current state, for observation
//   fifo            : write-FIFO interface (master side)
// -----------------------------------------------------------------------------
module pattern_burst_writer
    import pattern_pkg::*;
#(
    parameter int          DW            = 16,
    parameter int          BURST_LEN     = 8,
    parameter int          DEBOUNCE_CYC  = 1000,
    parameter logic [15:0] CONST_PATTERN = 16'hF81F,
    parameter logic [DW-1:0] SEED        = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_key,
    input  logic [1:0]                       i_mode,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [$clog2(BURST_LEN+1)-1:0]   o_words_written,
    output logic                             o_key_db,
    output state_t                           o_state,
    pattern_burst_writer_if.master           fifo
);

    localparam int            WW   = $clog2(BURST_LEN + 1);
    localparam logic [WW-1:0] LAST = WW'(BURST_LEN - 1);

    state_t        r_state;
    logic [1:0]    r_mode;
    logic [WW-1:0] r_words;    // doubles as the word index within the burst
    logic [DW-1:0] r_data;
    logic          w_press;
    logic          w_wr_en;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_key    (i_key),
        .o_key_db (o_key_db),
        .o_press  (w_press)
    );

    // Word i of the burst for pattern mode m; arithmetic wraps at 2^DW.
    function automatic logic [DW-1:0] f_pattern(input logic [1:0] m, input logic [WW-1:0] i);
        logic [DW-1:0] w;
        w = '0;
        case (m)
            PAT_CONST:   w = DW'(CONST_PATTERN);
            PAT_INC:     w = SEED + DW'(i);
            // MSB is 1 on even words, bits alternate below it.
            PAT_CHECKER: for (int b = 0; b < DW; b++) w[b] = (((DW - 1 - b) % 2) == 0) ^ i[0];
            PAT_WALK1:   w = DW'(1) << (int'(i) % DW);
            default:     w = '0;
        endcase
        return w;
    endfunction

    assign w_wr_en = (r_state == ST_RUN) & ~fifo.fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= PAT_CONST;
            r_words <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state <= ST_RUN;
                        r_mode  <= i_mode;
                        r_words <= '0;
                        r_data  <= f_pattern(i_mode, '0);
                    end
                end
                ST_RUN: begin
                    // Next word is prepared as the current one is accepted,
                    // so data only moves on acceptance and holds during stalls.
                    if (w_wr_en) begin
                        r_words <= r_words + 1'b1;
                        r_data  <= f_pattern(r_mode, r_words + 1'b1);
                        if (r_words == LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy            = (r_state == ST_RUN);
    assign o_done            = (r_state == ST_DONE);
    assign o_words_written   = r_words;
    assign o_state           = r_state;
    assign fifo.fifo_wr_clk  = clk;
    assign fifo.fifo_wr_en   = w_wr_en;
    assign fifo.fifo_wr_data = r_data;

endmodule

// File: tb/tb_pattern_burst_writer.sv
// -----------------------------------------------------------------------------
// tb_pattern_burst_writer
// Self-checking bench for pattern_burst_writer (DW=16, BURST_LEN=18,
// DEBOUNCE_CYC=4, SEED=16'hFFFE). A monitor records accepted words; each
// test compares them against an expected queue built from the pattern rules.
// -----------------------------------------------------------------------------
module tb_pattern_burst_writer;
    import pattern_pkg::*;

    localparam int DW  = 16;
    localparam int BL  = 18;
    localparam int DEB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_key = 1'b1;
    logic [1:0] i_mode = 2'd0;
    logic       o_busy;
    logic       o_done;
    logic       o_key_db;
    logic [4:0] o_words_written;
    state_t     o_state;

    pattern_burst_writer_if #(.DW(DW)) fifo_if ();

    pattern_burst_writer #(
        .DW            (DW),
        .BURST_LEN     (BL),
        .DEBOUNCE_CYC  (DEB),
        .CONST_PATTERN (16'hF81F),
        .SEED          (16'hFFFE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_key           (i_key),
        .i_mode          (i_mode),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_words_written (o_words_written),
        .o_key_db        (o_key_db),
        .o_state         (o_state),
        .fifo            (fifo_if)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] exp_q[$];
    int  first_en_cyc, last_en_cyc, done_cnt, done_cyc, done_with_busy, busy_cnt;
    bit  mon_clr = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            acc_q.delete();
            first_en_cyc   = -1;
            last_en_cyc    = -1;
            done_cnt       = 0;
            done_cyc       = -1;
            done_with_busy = 0;
            busy_cnt       = 0;
        end else if (rst_n) begin
            if (fifo_if.fifo_wr_en) begin
                acc_q.push_back(fifo_if.fifo_wr_data);
                if (first_en_cyc < 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (o_busy) done_with_busy++;
            end
            if (o_busy) busy_cnt++;
        end
    end

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_word(input int m, input int i);
        logic [15:0] seed;
        seed = 16'hFFFE;
        case (m)
            0:       return 16'hF81F;
            1:       return seed + 16'(i);
            2:       return (i % 2 == 0) ? 16'hAAAA : 16'h5555;
            default: return 16'(32'd1 << (i % 16));
        endcase
    endfunction

    task automatic build_exp(input int m);
        exp_q.delete();
        for (int i = 0; i < BL; i++) exp_q.push_back(model_word(m, i));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int budget, output bit to);
        for (int t = 0; t < budget && done_cnt == 0; t++) tick();
        to = (done_cnt == 0);
    endtask

    // Press with mode m; once busy, scramble i_mode to show it is ignored.
    task automatic run_burst(input int m, output bit to, output int k_fall);
        bit changed;
        changed = 1'b0;
        i_mode  = 2'(m);
        clear_mon();
        i_key   = 1'b0;
        k_fall  = cyc;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (o_busy && !changed) begin
                i_mode  = 2'($urandom_range(0, 3));
                changed = 1'b1;
            end
        end
        i_key = 1'b1;
        wait_done(200, to);
        repeat (10) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        fifo_if.fifo_full = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
        checks++; if (fifo_if.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", fifo_if.fifo_wr_en); end
        checks++; if (o_words_written !== 5'd0) begin errors++; $display("FAIL reset_words: got %0d expected 0", o_words_written); end
        checks++; if (fifo_if.fifo_wr_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", fifo_if.fifo_wr_data); end
        checks++; if (o_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", o_state, ST_IDLE); end
        checks++; if (o_key_db !== 1'b1) begin errors++; $display("FAIL reset_key_db: got %b expected 1", o_key_db); end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_const_burst();
        bit to; int k;
        run_burst(0, to, k);
        build_exp(0);
        checks++; if (to) begin errors++; $display("FAIL const_timeout: got no done expected done"); end
        checks++; if (acc_q.size() != BL) begin errors++; $display("FAIL const_count: got %0d expected %0d", acc_q.size(), BL); end
        for (int i = 0; i < BL && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL const_word%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
        end
        checks++; if (first_en_cyc != k + DEB + 2) begin errors++; $display("FAIL const_first_en: got cycle %0d expected %0d", first_en_cyc, k + DEB + 2); end
        checks++; if (last_en_cyc - first_en_cyc != BL - 1) begin errors++; $display("FAIL const_contiguous: got span %0d expected %0d", last_en_cyc - first_en_cyc, BL - 1); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL const_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc != last_en_cyc + 1) begin errors++; $display("FAIL const_done_cyc: got %0d expected %0d", done_cyc, last_en_cyc + 1); end
        checks++; if (done_with_busy != 0) begin errors++; $display("FAIL const_done_busy: got %0d expected 0", done_with_busy); end
        checks++; if (o_words_written !== 5'(BL)) begin errors++; $display("FAIL const_words: got %0d expected %0d", o_words_written, BL); end
    endtask

    task automatic test_glitch();
        int len;
        clear_mon();
        for (int p = 0; p < 3; p++) begin
            len   = $urandom_range(1, DEB - 1);
            i_key = 1'b0;
            repeat (len) tick();
            i_key = 1'b1;
            repeat (8) tick();
        end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL glitch_busy: got %0d cycles expected 0", busy_cnt); end
        checks++; if (acc_q.size() != 0) begin errors++; $display("FAIL glitch_writes: got %0d expected 0", acc_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL glitch_done: got %0d expected 0", done_cnt); end
        checks++; if (o_key_db !== 1'b1) begin errors++; $display("FAIL glitch_key_db: got %b expected 1", o_key_db); end
    endtask

    task automatic test_inc_burst();
        bit to; int k;
        logic [15:0] lit [4];
        lit = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        run_burst(1, to, k);
        build_exp(1);
        checks++; if (to) begin errors++; $display("FAIL inc_timeout: got no done expected done"); end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== lit[i]) begin errors++; $display("FAIL inc_head%0d: got %h expected %h", i, acc_q[i], lit[i]); end
        end
        checks++; if (acc_q.size() != BL) begin errors++; $display("FAIL inc_count: got %0d expected %0d", acc_q.size(), BL); end
        for (int i = 0; i < BL && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL inc_word%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_checker_walk();
        bit to; int k;
        for (int m = 2; m <= 3; m++) begin
            run_burst(m, to, k);
            build_exp(m);
            checks++; if (to) begin errors++; $display("FAIL mode%0d_timeout: got no done expected done", m); end
            checks++; if (acc_q.size() != BL) begin errors++; $display("FAIL mode%0d_count: got %0d expected %0d", m, acc_q.size(), BL); end
            for (int i = 0; i < BL && i < acc_q.size(); i++) begin
                checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL mode%0d_word%0d: got %h expected %h", m, i, acc_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit to; int t;
        i_mode = 2'd1;
        build_exp(1);
        clear_mon();
        i_key = 1'b0;
        t = 0;
        while (!(o_busy && o_words_written == 5'd3) && t < 40) begin tick(); t++; end
        i_key = 1'b1;
        checks++; if (t >= 40) begin errors++; $display("FAIL bp_wait_word3: got timeout expected word 3 pending"); end
        fifo_if.fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (fifo_if.fifo_wr_en !== 1'b0 || fifo_if.fifo_wr_data !== exp_q[3] || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: got en=%b data=%h busy=%b expected en=0 data=%h busy=1", c, fifo_if.fifo_wr_en, fifo_if.fifo_wr_data, o_busy, exp_q[3]);
            end
            tick();
        end
        fifo_if.fifo_full = 1'b0;
        t = 0;
        while (!(o_busy && o_words_written == 5'(BL - 1)) && t < 60) begin tick(); t++; end
        checks++; if (t >= 60) begin errors++; $display("FAIL bp_wait_last: got timeout expected last word pending"); end
        fifo_if.fifo_full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b1 || fifo_if.fifo_wr_en !== 1'b0 || fifo_if.fifo_wr_data !== exp_q[BL-1]) begin
                errors++;
                $display("FAIL bp_last%0d: got done=%b busy=%b en=%b data=%h expected done=0 busy=1 en=0 data=%h", c, o_done, o_busy, fifo_if.fifo_wr_en, fifo_if.fifo_wr_data, exp_q[BL-1]);
            end
            tick();
        end
        fifo_if.fifo_full = 1'b0;
        wait_done(20, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
        checks++; if (acc_q.size() != BL) begin errors++; $display("FAIL bp_count: got %0d expected %0d", acc_q.size(), BL); end
        for (int i = 0; i < BL && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1 || done_cyc != last_en_cyc + 1) begin errors++; $display("FAIL bp_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=%0d", done_cnt, done_cyc, last_en_cyc + 1); end
        repeat (10) tick();
    endtask

    task automatic test_press_in_run_and_reset();
        bit to; int t; int k;
        i_mode = 2'd3;
        build_exp(3);
        clear_mon();
        i_key = 1'b0; repeat (7) tick();
        i_key = 1'b1; repeat (7) tick();
        i_key = 1'b0; repeat (6) tick();   // second press lands while RUN
        i_key = 1'b1;
        wait_done(100, to);
        repeat (20) tick();
        checks++; if (to) begin errors++; $display("FAIL rerun_timeout: got no done expected done"); end
        checks++; if (acc_q.size() != BL) begin errors++; $display("FAIL rerun_count: got %0d expected %0d", acc_q.size(), BL); end
        for (int i = 0; i < BL && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rerun_word%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rerun_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (busy_cnt != BL) begin errors++; $display("FAIL rerun_busy_cnt: got %0d expected %0d", busy_cnt, BL); end

        // Abandon a burst part-way with an asynchronous reset.
        i_mode = 2'd1;
        clear_mon();
        i_key = 1'b0;
        t = 0;
        while (!(o_busy && o_words_written == 5'd5) && t < 40) begin tick(); t++; end
        i_key = 1'b1;
        checks++; if (t >= 40) begin errors++; $display("FAIL arst_wait: got timeout expected word 5 pending"); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fifo_if.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL arst_wr_en: got %b expected 0", fifo_if.fifo_wr_en); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", o_busy); end
        checks++; if (o_words_written !== 5'd0) begin errors++; $display("FAIL arst_words: got %0d expected 0", o_words_written); end
        checks++; if (fifo_if.fifo_wr_data !== 16'h0000) begin errors++; $display("FAIL arst_data: got %h expected 0000", fifo_if.fifo_wr_data); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        run_burst(1, to, k);
        build_exp(1);
        checks++; if (to) begin errors++; $display("FAIL fresh_timeout: got no done expected done"); end
        checks++; if (acc_q.size() != BL) begin errors++; $display("FAIL fresh_count: got %0d expected %0d", acc_q.size(), BL); end
        for (int i = 0; i < BL && i < acc_q.size(); i++) begin
            checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL fresh_word%0d: got %h expected %h", i, acc_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL fresh_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        fifo_if.fifo_full = 1'b0;
        test_reset();
        test_const_burst();
        test_glitch();
        test_inc_burst();
        test_checker_walk();
        test_backpressure();
        test_press_in_run_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_burst_writer.md
# pattern_burst_writer

Push-button-triggered test-pattern generator that writes one burst of BURST_LEN words into the SDRAM write FIFO. It debounces the key and honours FIFO backpressure. It produces constant, incrementing, checkerboard or walking-one data, so SDRAM controller and display paths can be exercised from the board without a camera.

## Interface

Parameters:
- DW, 16: data word width, at least 2.
- BURST_LEN, 8: words per burst, at least 1.
- DEBOUNCE_CYC, 1000: consecutive stable samples required to accept a key change, at least 1.
- CONST_PATTERN, 16'hF81F (zero-extended or truncated to DW): word used in mode 0.
- SEED, 0: first word in mode 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key  in  1  raw push button, active-low, asynchronous to clk.
- mode  in  2  pattern select, sampled at burst start.
- fifo_full  in  1  write FIFO full; no write while high.
- fifo_wr_clk  out  1  equals clk.
- fifo_wr_en  out  1  write strobe, combinational: busy & ~fifo_full.
- fifo_wr_data  out  DW  registered write word.
- busy  out  1  high while the state is RUN.
- done  out  1  one-cycle pulse after the last word is accepted.
- words_written  out  $clog2(BURST_LEN+1)  words accepted in the current or most recent burst.

## Operation

Key conditioning:
- key passes through a 2-FF synchronizer to give key_s.
- Stability counter: cleared while key_s == key_db; increments while they differ.
- When the counter equals DEBOUNCE_CYC-1 and key_s != key_db: key_db <= key_s and the counter clears.
- press is the combinational signal "key_db is 1 and updates to 0 at this edge".

State machine, states IDLE, RUN, DONE:
- IDLE -> RUN on press. At the same edge: mode is latched, idx <= 0, words_written <= 0, and fifo_wr_data <= pattern(0).
- RUN: a write is accepted at each edge where fifo_wr_en = 1. On acceptance, idx and words_written increment and fifo_wr_data <= pattern(idx+1).
- RUN -> DONE at the edge that accepts word BURST_LEN-1.
- DONE -> IDLE unconditionally after 1 cycle; done = 1 only in DONE.
- press in RUN or DONE is ignored. No restart and no queuing; key_db still tracks the key.

Patterns, where i is the word index and all arithmetic is mod 2^DW:
- Mode 0: CONST_PATTERN.
- Mode 1: SEED + i.
- Mode 2: {1010...} when i is even, {0101...} when i is odd. The MSB is 1 on even i.
- Mode 3: 1 << (i mod DW).

Boundary behaviour:
- fifo_full high for any duration stalls RUN. fifo_wr_data holds, no word is skipped or duplicated, and no timeout applies.
- If fifo_full is high on the final word, DONE waits until that word is accepted.
- Changing mode mid-burst has no effect.
- An asynchronous reset at any point forces the reset values below immediately; a partial burst is abandoned.

Reset values:
- state IDLE; key_db 1; synchronizer FFs 1.
- All counters 0; fifo_wr_data 0; words_written 0.
- busy, done, fifo_wr_en 0.

## Timing

- key falls before edge E0. key_s = 0 is visible after E1.
- key_db falls and the state enters RUN at edge E(1+DEBOUNCE_CYC).
- fifo_wr_en is first high in the following cycle. With no backpressure, word 0 is accepted at E(2+DEBOUNCE_CYC).
- Without stalls, words are accepted on BURST_LEN consecutive edges, one word per cycle.
- done is high in the cycle after the last acceptance. busy is low in that same cycle.
- A glitch on key_s shorter than DEBOUNCE_CYC cycles never changes key_db.

## Structure

- Shared package pattern_pkg holds:
  - mode constants PAT_CONST=0, PAT_INC=1, PAT_CHECKER=2, PAT_WALK1=3;
  - the state enum for IDLE, RUN, DONE.
- The synchronizer and debounce logic live in sub-module key_debounce, which outputs key_db and a press pulse.
- Pattern generation is a combinational function of mode and idx, placed inside the top module.

## Test plan

1. Reset, DEBOUNCE_CYC=4, mode 0, fifo_full=0, key held low for 10 cycles. Required: 8 consecutive writes of 16'hF81F, fifo_wr_en first high in the cycle after E5, done pulses once, words_written=8.
2. Key low pulses of 3 cycles, DEBOUNCE_CYC=4. Required: no busy and no writes.
3. Mode 1, SEED=16'hFFFE, BURST_LEN=4. Required data FFFE, FFFF, 0000, 0001.
4. Mode 2 then mode 3, DW=16, BURST_LEN=18. Checkerboard burst: AAAA, 5555, AAAA, ... Walking-one burst: 0001, 0002, ..., 8000, 0001, 0002.
5. fifo_full held high for 5 cycles after word 2, and again on the final word. Required: data frozen while full, exactly 8 unique ordered words, done only after the final word is accepted.
6. Second press during RUN, then rst_n low mid-burst. Required: the press does not restart or extend the burst. On reset, fifo_wr_en and busy go to 0 immediately and words_written = 0. A new press after reset starts a fresh burst at index 0.
